result_fifo_taint: RTL and testbench
====================================

Name: result_fifo_taint

Overview:
- Downstream consumer of the buffered multiplier: captures each (out_valid, out_result) pulse into a small FIFO.
- A downstream reader drains the FIFO with a valid/ready handshake.
- Every functional signal carries a 1-bit taint shadow, following the library's taint model.
- A PRECISE mode suppresses control taint when a tainted input cannot change state; this isolates dequeue-timing leakage from data leakage.

Parameters:
- WIDTH, 4, multiplier operand width; data width DW = 2*WIDTH = 8.
- DEPTH, 4, FIFO entries (power of two, >=2).
- PRECISE, 1, 1 = precise control-taint rules; 0 = conservative (any tainted control input taints control).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  enqueue request (mul/buffer out_valid).
- in_valid_t  in  1  taint of in_valid.
- in_data  in  DW  enqueue data (out_result).
- in_data_t  in  1  taint of in_data.
- out_ready  in  1  consumer ready.
- out_ready_t  in  1  taint of out_ready.
- out_valid  out  1  head entry valid (count != 0).
- out_valid_t  out  1  taint of out_valid.
- out_data  out  DW  head entry data.
- out_data_t  out  1  taint of out_data.
- full  out  1  count == DEPTH.
- full_t  out  1  taint of full.
- count  out  clog2(DEPTH+1)  occupancy.
- count_t  out  1  taint of count.
- overflow  out  1  sticky: an enqueue was dropped.
- overflow_t  out  1  taint of overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state:
  - count=0, wr_ptr=rd_ptr=0, overflow=0.
  - All taint state cleared: ctrl_t, overflow_t, every entry taint.
  - Hence out_valid=0, full=0, out_data=0, all *_t outputs = 0 the cycle after rst.
  - Reset mid-operation discards all contents; rst has priority over enq/deq.
- Handshake:
  - enq = in_valid && !full.
  - deq = out_valid && out_ready.
  - Both are evaluated on pre-edge state.
- Enqueue: mem[wr_ptr]<=in_data; ent_t[wr_ptr]<=in_data_t; wr_ptr wraps modulo DEPTH.
- Dequeue: rd_ptr advances, wrapping modulo DEPTH.
- count update: count += enq - deq. Simultaneous enq and deq leaves count unchanged.
- Full with in_valid=1: the input is dropped and overflow<=1 (sticky until rst). A same-cycle deq does not make room; no bypass.
- No empty bypass: data enqueued at edge N appears on out_valid/out_data after edge N (1-cycle latency).
- Outputs are combinational from state:
  - out_valid=(count!=0), full=(count==DEPTH).
  - out_data = mem[rd_ptr] when out_valid, else 0.
- Control taint ctrl_t (sticky, covers pointers and count):
  - PRECISE=0: ctrl_t <= ctrl_t | in_valid_t | out_ready_t.
  - PRECISE=1: ctrl_t <= ctrl_t | (in_valid_t & (!full | ctrl_t)) | (out_ready_t & (out_valid | ctrl_t)).
- Control taint outputs: out_valid_t = full_t = count_t = ctrl_t.
- Data taint: out_data_t = ctrl_t | (out_valid & ent_t[rd_ptr]).
  - An untainted head gives out_data_t=0 even if older dequeued entries were tainted.
- Overflow taint (sticky):
  - PRECISE=0: overflow_t <= overflow_t | in_valid_t | ctrl_t.
  - PRECISE=1: overflow_t <= overflow_t | (in_valid_t & (full | ctrl_t)) | ctrl_t.
- in_data_t never affects control taint.

Decomposition:
- Shared package taint_pkg: WIDTH, DW=2*WIDTH, clog2-based CNT_W helper.
- One natural sub-module, result_fifo_mem: DEPTH x (DW+1) storage with write port (addr, data, taint) and combinational read port (rd_ptr).
- Pointer, count and taint logic stay in the top module.

Test Plan:
- Basic order: rst then enqueue 0x06, 0x0C, 0x15 with out_ready=0. Expect count=3 and out_data=0x06 one cycle after the first enq. Drain with out_ready=1: out_data 0x06, 0x0C, 0x15, then out_valid=0 and out_data=0.
- Full/overflow: DEPTH=4, enqueue 5 values with out_ready=0. Expect full=1, count=4, overflow=1; the 5th value is never output. Do the same with simultaneous out_ready=1 on the 5th: still dropped, count=3 afterwards.
- Wrap-around: 10 interleaved enq/deq cycles, one enq and one deq per cycle at count=2. Expect count stays 2, data in order across pointer wrap, overflow=0.
- Data taint precision: enqueue 0x09 with in_data_t=1, then 0x04 with in_data_t=0, all control taint 0. Expect out_data_t=1 while 0x09 is head, 0 after it is dequeued; out_valid_t=full_t=count_t=0 throughout.
- PRECISE control taint: PRECISE=1, fifo empty, out_ready_t=1 for 3 cycles. Expect ctrl_t stays 0. Then enqueue once: ctrl_t still 0. Then hold out_ready_t=1 with out_valid=1: out_valid_t=1 next cycle and stays 1. With PRECISE=0 the first step already sets it.
- Reset mid-operation: fill 3 tainted entries with ctrl_t=1 and overflow=1, assert rst one cycle. Expect count=0, out_valid=0, overflow=0, all *_t=0. A following untainted enqueue shows out_data_t=0.

Source files
------------

// File: rtl/taint_pkg.sv
// Shared constants and helpers for the taint-tracked result path.
// Provides operand/data widths and the occupancy-counter width helper.
package taint_pkg;

  localparam int WIDTH = 4;
  localparam int DW    = 2 * WIDTH;

  // Width able to hold the values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/result_fifo_mem.sv
// FIFO storage: DEPTH entries of data plus a 1-bit taint per entry.
// Ports: clk/i_rst, write port (i_we,i_waddr,i_wdata,i_wtaint), comb read (i_raddr -> o_rdata,o_rtaint).
module result_fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_wtaint,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata,
  output logic          o_rtaint
);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_taint;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Entry taint is state that must not survive reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_taint <= '0;
    end else if (i_we) begin
      r_taint[i_waddr] <= i_wtaint;
    end
  end

  assign o_rdata  = r_mem[i_raddr];
  assign o_rtaint = r_taint[i_raddr];

endmodule

// File: rtl/result_fifo_taint.sv
// Result FIFO with 1-bit taint shadows on every functional signal.
// Ports: in_* enqueue side, out_* dequeue side, full/count/overflow status, each with a *_t taint.
module result_fifo_taint #(
  parameter int WIDTH   = taint_pkg::WIDTH,
  parameter int DEPTH   = 4,
  parameter bit PRECISE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_valid_t,
  input  logic [2*WIDTH-1:0]       in_data,
  input  logic                     in_data_t,
  input  logic                     out_ready,
  input  logic                     out_ready_t,
  output logic                     out_valid,
  output logic                     out_valid_t,
  output logic [2*WIDTH-1:0]       out_data,
  output logic                     out_data_t,
  output logic                     full,
  output logic                     full_t,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                     count_t,
  output logic                     overflow,
  output logic                     overflow_t
);

  import taint_pkg::*;

  localparam int DW = 2 * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_ctrl_t;
  logic          r_ovf_t;

  logic          w_valid;
  logic          w_full;
  logic          w_enq;
  logic          w_deq;
  logic [DW-1:0] w_rdata;
  logic          w_rtaint;
  logic          w_ctrl_t_nx;
  logic          w_ovf_t_nx;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_enq   = in_valid & ~w_full;
  assign w_deq   = w_valid & out_ready;

  result_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .i_rst    (rst),
    .i_we     (w_enq),
    .i_waddr  (r_wr_ptr),
    .i_wdata  (in_data),
    .i_wtaint (in_data_t),
    .i_raddr  (r_rd_ptr),
    .o_rdata  (w_rdata),
    .o_rtaint (w_rtaint)
  );

  // Precise mode ignores a tainted request that cannot move state:
  // enqueue into a full FIFO, or ready while empty.
  always_comb begin
    w_ctrl_t_nx = r_ctrl_t | in_valid_t | out_ready_t;
    w_ovf_t_nx  = r_ovf_t | in_valid_t | r_ctrl_t;
    if (PRECISE) begin
      w_ctrl_t_nx = r_ctrl_t
                  | (in_valid_t & (~w_full | r_ctrl_t))
                  | (out_ready_t & (w_valid | r_ctrl_t));
      w_ovf_t_nx  = r_ovf_t
                  | (in_valid_t & (w_full | r_ctrl_t))
                  | r_ctrl_t;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_ctrl_t <= 1'b0;
      r_ovf_t  <= 1'b0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_valid & w_full) r_ovf <= 1'b1;
      r_ctrl_t <= w_ctrl_t_nx;
      r_ovf_t  <= w_ovf_t_nx;
    end
  end

  assign out_valid   = w_valid;
  assign full        = w_full;
  assign count       = r_count;
  assign overflow    = r_ovf;
  assign out_data    = w_valid ? w_rdata : '0;
  assign out_valid_t = r_ctrl_t;
  assign full_t      = r_ctrl_t;
  assign count_t     = r_ctrl_t;
  assign out_data_t  = r_ctrl_t | (w_valid & w_rtaint);
  assign overflow_t  = r_ovf_t;

endmodule

// File: tb/tb_result_fifo_taint.sv
// Bench for result_fifo_taint: precise and conservative instances share stimulus.
// A queue model predicts every output; directed steps pin literal values.
module tb_result_fifo_taint;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_valid_t = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_data_t = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_ready_t = 1'b0;

  // index 0: PRECISE=0, index 1: PRECISE=1
  logic [1:0] o_valid, o_valid_t, o_data_t;
  logic [1:0] o_full, o_full_t, o_cnt_t;
  logic [1:0] o_ovf, o_ovf_t;
  logic [7:0] o_data [2];
  logic [2:0] o_cnt [2];

  int vec = 0;
  int mis = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    result_fifo_taint #(
      .WIDTH   (4),
      .DEPTH   (DEPTH),
      .PRECISE (g[0])
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_valid_t  (in_valid_t),
      .in_data     (in_data),
      .in_data_t   (in_data_t),
      .out_ready   (out_ready),
      .out_ready_t (out_ready_t),
      .out_valid   (o_valid[g]),
      .out_valid_t (o_valid_t[g]),
      .out_data    (o_data[g]),
      .out_data_t  (o_data_t[g]),
      .full        (o_full[g]),
      .full_t      (o_full_t[g]),
      .count       (o_cnt[g]),
      .count_t     (o_cnt_t[g]),
      .overflow    (o_ovf[g]),
      .overflow_t  (o_ovf_t[g])
    );
  end

  task automatic chk(input string nm, input int p,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      mis++;
      $display("FAIL %s[P%0d] got=%0h exp=%0h t=%0t",
               nm, p, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       t;
  } ent_s;

  ent_s q[$];
  bit   m_ovf;
  bit   m_ct [2];
  bit   m_ot [2];
  bit   armed = 0;

  // Model update from the inputs seen at the edge.
  always @(posedge clk) begin
    bit mfull, mvalid, pr;
    ent_s e;
    mfull  = (q.size() == DEPTH);
    mvalid = (q.size() != 0);
    if (rst) begin
      q.delete();
      m_ovf = 0;
      for (int p = 0; p < 2; p++) begin
        m_ct[p] = 0;
        m_ot[p] = 0;
      end
      armed = 1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        pr = (p == 1);
        if (pr) begin
          m_ot[p] = m_ot[p] | (in_valid_t & (mfull | m_ct[p]))
                  | m_ct[p];
          m_ct[p] = m_ct[p] | (in_valid_t & (!mfull | m_ct[p]))
                  | (out_ready_t & (mvalid | m_ct[p]));
        end else begin
          m_ot[p] = m_ot[p] | in_valid_t | m_ct[p];
          m_ct[p] = m_ct[p] | in_valid_t | out_ready_t;
        end
      end
      if (mvalid && out_ready) void'(q.pop_front());
      if (in_valid && !mfull) begin
        e.d = in_data;
        e.t = in_data_t;
        q.push_back(e);
      end
      if (in_valid && mfull) m_ovf = 1;
    end
  end

  // Compare every cycle once a reset has been seen.
  always @(negedge clk) begin
    int n;
    logic [7:0] hd;
    logic ht;
    if (armed) begin
      n  = q.size();
      hd = (n != 0) ? q[0].d : 8'h00;
      ht = (n != 0) ? q[0].t : 1'b0;
      for (int p = 0; p < 2; p++) begin
        chk("out_valid", p, o_valid[p], n != 0);
        chk("full", p, o_full[p], n == DEPTH);
        chk("count", p, o_cnt[p], n);
        chk("out_data", p, o_data[p], hd);
        chk("overflow", p, o_ovf[p], m_ovf);
        chk("out_valid_t", p, o_valid_t[p], m_ct[p]);
        chk("full_t", p, o_full_t[p], m_ct[p]);
        chk("count_t", p, o_cnt_t[p], m_ct[p]);
        chk("out_data_t", p, o_data_t[p], m_ct[p] | ht);
        chk("overflow_t", p, o_ovf_t[p], m_ot[p]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic enq(input logic [7:0] d, input logic t);
    in_valid  = 1'b1;
    in_data   = d;
    in_data_t = t;
    step();
    in_valid  = 1'b0;
    in_data_t = 1'b0;
  endtask

  initial begin
    do_rst();
    chk("rst_count", 1, o_cnt[1], 0);
    chk("rst_valid", 1, o_valid[1], 0);

    // basic order
    enq(8'h06, 0);
    chk("lit_head06", 1, o_data[1], 8'h06);
    enq(8'h0C, 0);
    enq(8'h15, 0);
    chk("lit_cnt3", 1, o_cnt[1], 3);
    out_ready = 1'b1;
    chk("lit_d0", 1, o_data[1], 8'h06);
    step();
    chk("lit_d1", 1, o_data[1], 8'h0C);
    step();
    chk("lit_d2", 1, o_data[1], 8'h15);
    step();
    chk("lit_empty", 1, o_valid[1], 0);
    chk("lit_zero", 1, o_data[1], 0);
    out_ready = 1'b0;

    // full / overflow
    do_rst();
    for (int i = 1; i <= 5; i++) enq(8'(i), 0);
    chk("lit_full", 1, o_full[1], 1);
    chk("lit_cnt4", 1, o_cnt[1], 4);
    chk("lit_ovf", 1, o_ovf[1], 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("lit_drain", 1, o_data[1], i);
      step();
    end
    chk("lit_no5", 1, o_valid[1], 0);
    out_ready = 1'b0;

    do_rst();
    for (int i = 1; i <= 4; i++) enq(8'(i), 0);
    out_ready = 1'b1;
    enq(8'h05, 0);
    out_ready = 1'b0;
    chk("lit_cnt3b", 1, o_cnt[1], 3);
    chk("lit_head2", 1, o_data[1], 8'h02);

    // wrap-around at count 2
    do_rst();
    enq(8'hA0, 0);
    enq(8'hA1, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) enq(8'hA2 + 8'(i), 0);
    out_ready = 1'b0;
    chk("lit_wcnt", 1, o_cnt[1], 2);
    chk("lit_whead", 1, o_data[1], 8'hAA);
    chk("lit_wovf", 1, o_ovf[1], 0);

    // data taint precision
    do_rst();
    enq(8'h09, 1);
    enq(8'h04, 0);
    chk("lit_dt1", 0, o_data_t[0], 1);
    chk("lit_dt1", 1, o_data_t[1], 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("lit_dhead", 1, o_data[1], 8'h04);
    chk("lit_dt0", 1, o_data_t[1], 0);
    chk("lit_vt0", 0, o_valid_t[0], 0);

    // precise control taint
    do_rst();
    out_ready   = 1'b1;
    out_ready_t = 1'b1;
    repeat (3) step();
    chk("lit_ct_p", 1, o_valid_t[1], 0);
    chk("lit_ct_c", 0, o_valid_t[0], 1);
    enq(8'h11, 0);
    chk("lit_ct_enq", 1, o_valid_t[1], 0);
    out_ready = 1'b0;
    step();
    chk("lit_ct_set", 1, o_valid_t[1], 1);
    step();
    chk("lit_ct_hold", 1, o_valid_t[1], 1);
    out_ready_t = 1'b0;

    // reset mid-operation
    do_rst();
    in_valid_t = 1'b1;
    for (int i = 0; i < 5; i++) enq(8'h40 + 8'(i), 1);
    in_valid_t = 1'b0;
    out_ready  = 1'b1;
    step();
    out_ready  = 1'b0;
    chk("lit_m_cnt", 1, o_cnt[1], 3);
    chk("lit_m_ct", 1, o_valid_t[1], 1);
    chk("lit_m_ovf", 1, o_ovf[1], 1);
    do_rst();
    chk("lit_r_cnt", 1, o_cnt[1], 0);
    chk("lit_r_ovf", 1, o_ovf[1], 0);
    chk("lit_r_ovt", 1, o_ovf_t[1], 0);
    chk("lit_r_vt", 0, o_valid_t[0], 0);
    enq(8'h33, 0);
    chk("lit_r_dt", 1, o_data_t[1], 0);
    chk("lit_r_dt", 0, o_data_t[0], 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      in_valid    = $urandom_range(0, 1) == 1;
      in_data     = 8'($urandom);
      in_data_t   = ($urandom_range(0, 3) == 0);
      in_valid_t  = ($urandom_range(0, 15) == 0);
      out_ready   = $urandom_range(0, 1) == 1;
      out_ready_t = ($urandom_range(0, 15) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
